// File: rtl/bcd_timer_n.sv
// N-digit synchronous BCD up/down timer with an internal prescaler, pause,
// parallel load and wrap-or-stop handling at the terminal count.
module bcd_timer_n #(
   parameter int DIGITS = 3,
   parameter int DIV    = 50000000,
   parameter int DIV_W  = 26,
   parameter int WRAP   = 1
) (
   input  logic                  CLOCK_50,
   input  logic                  Resetn,
   input  logic                  run,
   input  logic                  up_dn,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tick,
   output logic                  tc,
   output logic                  done
);

   localparam int W = 4 * DIGITS;

   localparam logic [1:0] ST_PAUSE   = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_EXPIRED = 2'd2;

   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);
   localparam logic [W-1:0]     ZEROS    = {W{1'b0}};

   // Forces any non-decimal nibble of a loaded value to 9.
   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   d;
      r = ZEROS;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (d > 4'd9) begin
            r[4*i +: 4] = 4'd9;
         end else begin
            r[4*i +: 4] = d;
         end
      end
      return r;
   endfunction

   // All digits at 9: the terminal value when counting up.
   function automatic logic [W-1:0] all_nines();
      logic [W-1:0] r;
      r = ZEROS;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // One BCD step; the carry/borrow chain ripples combinationally so every
   // digit settles on the same clock edge.
   function automatic logic [W-1:0] step_bcd(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic [3:0]   d;
      logic         cy;
      r  = ZEROS;
      cy = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (!cy) begin
            r[4*i +: 4] = d;
         end else if (up) begin
            if (d >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = d + 4'd1;
               cy          = 1'b0;
            end
         end else begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               cy          = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [W-1:0] NINES = all_nines();

   logic [1:0]       state_r;
   logic [DIV_W-1:0] pre_r;
   logic [W-1:0]     bcd_r;
   logic             tick_r;
   logic             tc_r;
   logic             done_r;

   logic [1:0]       state_nxt_s;
   logic [1:0]       run_state_s;
   logic [DIV_W-1:0] pre_nxt_s;
   logic [W-1:0]     bcd_nxt_s;
   logic             tick_nxt_s;
   logic             tc_nxt_s;
   logic             term_s;

   // Next-state logic: clear > load > count step, with the terminal decision.
   always_comb begin
      state_nxt_s = state_r;
      pre_nxt_s   = pre_r;
      bcd_nxt_s   = bcd_r;
      tick_nxt_s  = 1'b0;
      tc_nxt_s    = 1'b0;
      run_state_s = run ? ST_RUN : ST_PAUSE;
      if (up_dn) begin
         term_s = (bcd_r == NINES);
      end else begin
         term_s = (bcd_r == ZEROS);
      end

      if (clear || load) begin
         // Any step coinciding with clear/load is dropped.
         pre_nxt_s = {DIV_W{1'b0}};
         if (clear) begin
            bcd_nxt_s = ZEROS;
         end else begin
            bcd_nxt_s = clamp_bcd(load_val);
         end
         if (state_r == ST_EXPIRED) begin
            state_nxt_s = ST_PAUSE;
         end else begin
            state_nxt_s = run_state_s;
         end
      end else begin
         case (state_r)
            ST_PAUSE: begin
               state_nxt_s = run_state_s;
            end
            ST_RUN: begin
               if (!run) begin
                  state_nxt_s = ST_PAUSE;
               end else if (pre_r == PRE_LAST) begin
                  pre_nxt_s  = {DIV_W{1'b0}};
                  tick_nxt_s = 1'b1;
                  if (term_s) begin
                     tc_nxt_s = 1'b1;
                     if (WRAP != 0) begin
                        bcd_nxt_s = step_bcd(bcd_r, up_dn);
                     end else begin
                        state_nxt_s = ST_EXPIRED;
                     end
                  end else begin
                     bcd_nxt_s = step_bcd(bcd_r, up_dn);
                  end
               end else begin
                  pre_nxt_s = pre_r + PRE_ONE;
               end
            end
            ST_EXPIRED: begin
               pre_nxt_s = {DIV_W{1'b0}};
            end
            default: begin
               state_nxt_s = ST_PAUSE;
               pre_nxt_s   = {DIV_W{1'b0}};
            end
         endcase
      end
   end

   // State, prescaler and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= ST_PAUSE;
         pre_r   <= {DIV_W{1'b0}};
         bcd_r   <= ZEROS;
         tick_r  <= 1'b0;
         tc_r    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pre_r   <= pre_nxt_s;
         bcd_r   <= bcd_nxt_s;
         tick_r  <= tick_nxt_s;
         tc_r    <= tc_nxt_s;
         done_r  <= (state_nxt_s == ST_EXPIRED);
      end
   end

   assign bcd  = bcd_r;
   assign tick = tick_r;
   assign tc   = tc_r;
   assign done = done_r;

endmodule
